nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Serial 16-bit adder/subtractor: one nibble per cycle through a shared
// 4-bit ripple adder, sequenced by an IDLE/RUN/DONE state machine.

// 4-bit ripple-carry adder used as the shared nibble datapath.
module four_bit_parallel_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic c1_s;
    logic c2_s;
    logic c3_s;

    assign s[0] = a[0] ^ b[0] ^ cin;
    assign c1_s = (a[0] & b[0]) | (cin  & (a[0] ^ b[0]));
    assign s[1] = a[1] ^ b[1] ^ c1_s;
    assign c2_s = (a[1] & b[1]) | (c1_s & (a[1] ^ b[1]));
    assign s[2] = a[2] ^ b[2] ^ c2_s;
    assign c3_s = (a[2] & b[2]) | (c2_s & (a[2] ^ b[2]));
    assign s[3] = a[3] ^ b[3] ^ c3_s;
    assign cout = (a[3] & b[3]) | (c3_s & (a[3] ^ b[3]));
endmodule

module nibble_serial_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    input  logic        sub,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    // Operands are captured at acceptance; B is stored already inverted for
    // subtraction so the datapath is always a plain add.
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        sub_q;
    logic        carry_q;
    logic [1:0]  idx;

    logic        busy_r;
    logic        done_r;
    logic [15:0] sum_r;
    logic        cout_r;
    logic        ovf_r;

    logic [3:0]  nib_a_s;
    logic [3:0]  nib_b_s;
    logic [3:0]  nib_s_s;
    logic        nib_cout_s;

    assign nib_a_s = a_q[{idx, 2'b00} +: 4];
    assign nib_b_s = b_q[{idx, 2'b00} +: 4];

    four_bit_parallel_adder u_nib_add (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .cin  (carry_q),
        .s    (nib_s_s),
        .cout (nib_cout_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: starts are only honoured from IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (idx == 2'd3) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx     <= 2'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= 16'h0000;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        sub_q   <= sub;
                        carry_q <= sub ? 1'b1 : cin;
                        idx     <= 2'd0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_r[{idx, 2'b00} +: 4] <= nib_s_s;
                    carry_q                  <= nib_cout_s;
                    idx                      <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        // Overflow: operands agree in sign but result does not.
                        cout_r <= nib_cout_s;
                        ovf_r  <= (a_q[15] ~^ b_q[15]) & (nib_s_s[3] ^ a_q[15]);
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
endmodule
